// File: rtl/gfx_cmd_issuer.sv
// Bus initiator that replays one drawing request as register writes on the
// graphics controller's 68k-style interface, then polls status until idle.
module gfx_cmd_issuer #(
    parameter logic [7:0] BASE_HI       = 8'h00,
    parameter int         STROBE_CYCLES = 2,
    parameter int         GAP_CYCLES    = 2,
    parameter int         MAX_POLLS     = 1024
) (
    input  logic        Clk,
    input  logic        Reset_L,
    // Handshake: a request transfers on the rising edge where req_valid && req_ready;
    // req_ready is high only while idle, and req_* are captured on that edge.
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_cmd,
    input  logic [15:0] req_x1,
    input  logic [15:0] req_y1,
    input  logic [15:0] req_x2,
    input  logic [15:0] req_y2,
    input  logic [15:0] req_colour,
    input  logic [15:0] req_fill,
    output logic        busy,
    output logic        done,
    output logic        err_timeout,
    output logic [15:0] AddressOut,
    output logic [15:0] DataOut,
    input  logic [15:0] DataIn,
    output logic        AS_L,
    output logic        UDS_L,
    output logic        LDS_L,
    output logic        RW,
    output logic        GraphicsCS_L,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_SETUP       = 3'd1,
        S_STROBE      = 3'd2,
        S_GAP         = 3'd3,
        S_POLL_SETUP  = 3'd4,
        S_POLL_STROBE = 3'd5,
        S_POLL_GAP    = 3'd6,
        S_DONE        = 3'd7
    } state_t;

    localparam logic [7:0]  STROBE_LAST = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0]  GAP_LAST    = 8'(GAP_CYCLES - 1);
    localparam logic [15:0] POLL_LAST   = 16'(MAX_POLLS - 1);

    state_t      state, state_nxt;
    logic [15:0] r_cmd, r_x1, r_y1, r_x2, r_y2, r_colour, r_fill;
    logic [2:0]  pos, pos_nxt;
    logic [7:0]  cnt;
    logic [15:0] poll_cnt;
    logic        err_q;
    logic        accept, strobe_last, gap_last, last_write, poll_timeout;
    logic [6:0]  wr_idx;
    logic [15:0] wr_data;
    logic        status_unused;

    assign accept        = req_valid && (state == S_IDLE);
    assign strobe_last   = (cnt == STROBE_LAST);
    assign gap_last      = (cnt == GAP_LAST);
    assign last_write    = (pos == 3'd6);
    assign poll_timeout  = (poll_cnt == POLL_LAST);
    assign status_unused = ^DataIn[15:1];
    assign dbg_state     = state;

    // Write list slots 0..6; the fill slot (5) is skipped unless the command is Circle.
    always_comb begin
        pos_nxt = pos + 3'd1;
        if (pos == 3'd4 && r_cmd != 16'd5)
            pos_nxt = 3'd6;
    end

    always_comb begin
        wr_idx  = 7'd0;
        wr_data = r_cmd;
        case (pos)
            3'd0: begin wr_idx = 7'd1; wr_data = r_x1;     end
            3'd1: begin wr_idx = 7'd2; wr_data = r_y1;     end
            3'd2: begin wr_idx = 7'd3; wr_data = r_x2;     end
            3'd3: begin wr_idx = 7'd4; wr_data = r_y2;     end
            3'd4: begin wr_idx = 7'd7; wr_data = r_colour; end
            3'd5: begin wr_idx = 7'd8; wr_data = r_fill;   end
            default: begin wr_idx = 7'd0; wr_data = r_cmd; end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:        if (accept) state_nxt = S_SETUP;
            S_SETUP:       state_nxt = S_STROBE;
            S_STROBE:      if (strobe_last) state_nxt = S_GAP;
            S_GAP:         if (gap_last) state_nxt = last_write ? S_POLL_SETUP : S_SETUP;
            S_POLL_SETUP:  state_nxt = S_POLL_STROBE;
            // Status is sampled on the last strobe clock; a finished poll skips the gap.
            S_POLL_STROBE: if (strobe_last)
                               state_nxt = (!DataIn[0] || poll_timeout) ? S_DONE : S_POLL_GAP;
            S_POLL_GAP:    if (gap_last) state_nxt = S_POLL_SETUP;
            S_DONE:        state_nxt = S_IDLE;
            default:       state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            r_cmd    <= '0;
            r_x1     <= '0;
            r_y1     <= '0;
            r_x2     <= '0;
            r_y2     <= '0;
            r_colour <= '0;
            r_fill   <= '0;
            pos      <= '0;
            cnt      <= '0;
            poll_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                r_cmd    <= req_cmd;
                r_x1     <= req_x1;
                r_y1     <= req_y1;
                r_x2     <= req_x2;
                r_y2     <= req_y2;
                r_colour <= req_colour;
                r_fill   <= req_fill;
                pos      <= '0;
                poll_cnt <= '0;
                err_q    <= 1'b0;
            end
            if (state == S_IDLE || state_nxt != state)
                cnt <= '0;
            else
                cnt <= cnt + 8'd1;
            if (state == S_GAP && gap_last && !last_write)
                pos <= pos_nxt;
            if (state == S_POLL_STROBE && strobe_last && DataIn[0]) begin
                poll_cnt <= poll_cnt + 16'd1;
                if (poll_timeout)
                    err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        AS_L         = 1'b1;
        RW           = 1'b1;
        AddressOut   = {BASE_HI, 8'h00};
        DataOut      = 16'h0000;
        busy         = (state != S_IDLE);
        done         = (state == S_DONE);
        req_ready    = (state == S_IDLE);
        err_timeout  = err_q;
        case (state)
            S_SETUP, S_STROBE, S_GAP: begin
                AddressOut = {BASE_HI, wr_idx, 1'b0};
                DataOut    = wr_data;
                RW         = 1'b0;
                AS_L       = (state != S_STROBE);
            end
            S_POLL_SETUP, S_POLL_STROBE, S_POLL_GAP: begin
                AS_L = (state != S_POLL_STROBE);
            end
            default: ;
        endcase
        UDS_L        = AS_L;
        LDS_L        = AS_L;
        GraphicsCS_L = AS_L;
    end

endmodule

// File: tb/tb_gfx_cmd_issuer.sv
// Randomized bench for gfx_cmd_issuer: a per-cycle trace model built from the
// access timing rules, a status responder, a bus log and literal spot checks.
module tb_gfx_cmd_issuer;
    localparam int SC = 2;
    localparam int GC = 2;
    localparam int MP = 4;

    logic        Clk = 1'b0;
    logic        Reset_L = 1'b0;
    logic        req_valid = 1'b0;
    logic [15:0] req_cmd = '0, req_x1 = '0, req_y1 = '0, req_x2 = '0, req_y2 = '0;
    logic [15:0] req_colour = '0, req_fill = '0;
    logic [15:0] DataIn = '0;
    logic        req_ready, busy, done, err_timeout;
    logic [15:0] AddressOut, DataOut;
    logic        AS_L, UDS_L, LDS_L, RW, GraphicsCS_L;
    logic [2:0]  dbg_state;

    always #5 Clk = ~Clk;

    gfx_cmd_issuer #(.BASE_HI(8'h00), .STROBE_CYCLES(SC), .GAP_CYCLES(GC), .MAX_POLLS(MP)) dut (
        .Clk(Clk), .Reset_L(Reset_L), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_x1(req_x1), .req_y1(req_y1), .req_x2(req_x2), .req_y2(req_y2),
        .req_colour(req_colour), .req_fill(req_fill), .busy(busy), .done(done),
        .err_timeout(err_timeout), .AddressOut(AddressOut), .DataOut(DataOut), .DataIn(DataIn),
        .AS_L(AS_L), .UDS_L(UDS_L), .LDS_L(LDS_L), .RW(RW), .GraphicsCS_L(GraphicsCS_L),
        .dbg_state(dbg_state)
    );

    typedef struct packed {
        logic        as_l;
        logic        rw;
        logic        addr_care;
        logic [15:0] addr;
        logic        data_care;
        logic [15:0] data;
        logic        busy;
        logic        done;
        logic        err;
    } rec_t;

    rec_t        exp_q[$];
    logic [32:0] log_q[$];
    logic [32:0] tab[$];
    int          checks = 0;
    int          errors = 0;
    int          acc_cnt = 0;
    int          done_cnt = 0;
    int          n_next = 0;
    int          cur_n = 0;
    int          poll_seen = 0;
    int          cyc = 0;
    bit          model_idle = 1'b1;
    logic        model_err = 1'b0;
    logic        prev_as_l = 1'b1;

    // One bus access as seen cycle by cycle: setup, strobe, optional gap.
    task automatic push_access(input logic rw, input logic [6:0] idx, input logic [15:0] d, input bit gap);
        rec_t r;
        r = '0;
        r.rw = rw;
        r.addr_care = 1'b1;
        r.addr = {8'h00, idx, 1'b0};
        r.data_care = ~rw;
        r.data = d;
        r.busy = 1'b1;
        r.as_l = 1'b1;
        exp_q.push_back(r);
        r.as_l = 1'b0;
        for (int i = 0; i < SC; i++) exp_q.push_back(r);
        r.as_l = 1'b1;
        if (gap) for (int i = 0; i < GC; i++) exp_q.push_back(r);
    endtask

    task automatic build_trace(input logic [15:0] c, x1, y1, x2, y2, col, fl, input int n);
        rec_t r;
        int nreads;
        push_access(1'b0, 7'd1, x1, 1'b1);
        push_access(1'b0, 7'd2, y1, 1'b1);
        push_access(1'b0, 7'd3, x2, 1'b1);
        push_access(1'b0, 7'd4, y2, 1'b1);
        push_access(1'b0, 7'd7, col, 1'b1);
        if (c == 16'd5) push_access(1'b0, 7'd8, fl, 1'b1);
        push_access(1'b0, 7'd0, c, 1'b1);
        nreads = (n >= MP) ? MP : n + 1;
        for (int k = 0; k < nreads; k++) push_access(1'b1, 7'd0, 16'h0, k < nreads - 1);
        r = '0;
        r.as_l = 1'b1;
        r.rw = 1'b1;
        r.busy = 1'b1;
        r.done = 1'b1;
        r.err = (n >= MP);
        exp_q.push_back(r);
    endtask

    // Model, status responder, bus log and per-cycle compare share one process.
    initial begin
        rec_t        e;
        logic        mism;
        logic [14:0] junk;
        forever begin
            @(posedge Clk);
            if (Reset_L && req_valid && model_idle) begin
                build_trace(req_cmd, req_x1, req_y1, req_x2, req_y2, req_colour, req_fill, n_next);
                cur_n = n_next;
                poll_seen = 0;
                acc_cnt++;
                model_err = 1'b0;
                model_idle = 1'b0;
            end
            @(negedge Clk);
            cyc++;
            if (!Reset_L) begin
                exp_q.delete();
                model_idle = 1'b1;
                model_err = 1'b0;
                prev_as_l = 1'b1;
            end else begin
                if (!AS_L && prev_as_l) begin
                    log_q.push_back({RW, AddressOut, DataOut});
                    if (RW) begin
                        junk = 15'($urandom);
                        DataIn = {junk, 1'(poll_seen < cur_n)};
                        poll_seen++;
                    end
                end
                prev_as_l = AS_L;
                if (done) done_cnt++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    model_idle = 1'b0;
                    if (e.done) model_err = e.err;
                end else begin
                    e = '0;
                    e.as_l = 1'b1;
                    e.rw = 1'b1;
                    e.err = model_err;
                    model_idle = 1'b1;
                end
                mism = (AS_L !== e.as_l) || (UDS_L !== e.as_l) || (LDS_L !== e.as_l) ||
                       (GraphicsCS_L !== e.as_l) || (RW !== e.rw) ||
                       (e.addr_care && AddressOut !== e.addr) || (e.data_care && DataOut !== e.data) ||
                       (busy !== e.busy) || (done !== e.done) || (req_ready !== !e.busy) ||
                       (err_timeout !== e.err);
                checks++;
                if (mism) begin
                    errors++;
                    $display("FAIL cycle_check cyc=%0d got as=%b uds=%b lds=%b cs=%b rw=%b addr=%h data=%h busy=%b done=%b ready=%b err=%b, expected as=%b rw=%b addr=%h data=%h busy=%b done=%b err=%b",
                             cyc, AS_L, UDS_L, LDS_L, GraphicsCS_L, RW, AddressOut, DataOut, busy, done,
                             req_ready, err_timeout, e.as_l, e.rw, e.addr, e.data, e.busy, e.done, e.err);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tw(input logic [15:0] a, input logic [15:0] d);
        tab.push_back({1'b0, a, d});
    endtask

    task automatic tr(input logic [15:0] a);
        tab.push_back({1'b1, a, 16'h0});
    endtask

    // Compares the bus log from index base against the hand-written table.
    task automatic check_log(input int base, input string nm);
        logic [32:0] got;
        logic [32:0] want;
        chk({nm, "_count"}, 32'(log_q.size() - base), 32'(tab.size()));
        for (int i = 0; i < tab.size() && base + i < log_q.size(); i++) begin
            got = log_q[base + i];
            want = tab[i];
            if (want[32]) got[15:0] = 16'h0;
            chk($sformatf("%s_access%0d", nm, i), 32'(got), 32'(want));
        end
        tab.delete();
    endtask

    task automatic send(input logic [15:0] c, a, b, d, f, col, fl, input int n, input bit keep);
        int a0;
        a0 = acc_cnt;
        req_cmd = c; req_x1 = a; req_y1 = b; req_x2 = d; req_y2 = f;
        req_colour = col; req_fill = fl;
        n_next = n;
        req_valid = 1'b1;
        for (int i = 0; i < 3000 && acc_cnt == a0; i++) begin
            @(posedge Clk); #1;
        end
        if (acc_cnt == a0) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no acceptance expected acceptance within 3000 cycles");
        end
        req_cmd = 16'($urandom); req_x1 = 16'($urandom); req_y1 = 16'($urandom);
        req_x2 = 16'($urandom); req_y2 = 16'($urandom);
        req_colour = 16'($urandom); req_fill = 16'($urandom);
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 3000 && !(model_idle && exp_q.size() == 0); i++) begin
            @(posedge Clk); #1;
        end
        if (i >= 3000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy expected idle within 3000 cycles");
        end
    endtask

    initial begin
        int base;
        int d0;
        logic [15:0] cmds [10];
        cmds = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd10, 16'd11, 16'd16, 16'd0, 16'hBEEF};

        // Reset values while held in reset.
        #12;
        chk("rst_as", 32'(AS_L), 32'h1);
        chk("rst_uds", 32'(UDS_L), 32'h1);
        chk("rst_lds", 32'(LDS_L), 32'h1);
        chk("rst_cs", 32'(GraphicsCS_L), 32'h1);
        chk("rst_rw", 32'(RW), 32'h1);
        chk("rst_addr", 32'(AddressOut), 32'h0);
        chk("rst_data", 32'(DataOut), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(err_timeout), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h1);
        @(negedge Clk); #2;
        Reset_L = 1'b1;
        repeat (2) @(posedge Clk);
        #1;

        // Circle, idle on first poll.
        base = log_q.size();
        send(16'd5, 16'd360, 16'd360, 16'd40, 16'd10, 16'd4, 16'd4, 0, 1'b0);
        wait_idle();
        tw(16'h0002, 16'd360); tw(16'h0004, 16'd360); tw(16'h0006, 16'd40); tw(16'h0008, 16'd10);
        tw(16'h000E, 16'd4); tw(16'h0010, 16'd4); tw(16'h0000, 16'd5); tr(16'h0000);
        check_log(base, "circle");
        chk("circle_err", 32'(err_timeout), 32'h0);

        // ALine: no fill access.
        base = log_q.size();
        send(16'd3, 16'd100, 16'd100, 16'd150, 16'd150, 16'd2, 16'd9, 0, 1'b0);
        wait_idle();
        tw(16'h0002, 16'd100); tw(16'h0004, 16'd100); tw(16'h0006, 16'd150); tw(16'h0008, 16'd150);
        tw(16'h000E, 16'd2); tw(16'h0000, 16'd3); tr(16'h0000);
        check_log(base, "aline");

        // Status busy for three polls, then idle.
        base = log_q.size();
        send(16'd1, 16'd7, 16'd8, 16'd9, 16'd10, 16'd11, 16'd12, 3, 1'b0);
        wait_idle();
        tw(16'h0002, 16'd7); tw(16'h0004, 16'd8); tw(16'h0006, 16'd9); tw(16'h0008, 16'd10);
        tw(16'h000E, 16'd11); tw(16'h0000, 16'd1);
        tr(16'h0000); tr(16'h0000); tr(16'h0000); tr(16'h0000);
        check_log(base, "busy3");
        chk("busy3_err", 32'(err_timeout), 32'h0);

        // Status stuck busy: timeout after MAX_POLLS reads, error held.
        base = log_q.size();
        d0 = done_cnt;
        send(16'd2, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 50, 1'b0);
        wait_idle();
        tw(16'h0002, 16'd1); tw(16'h0004, 16'd2); tw(16'h0006, 16'd3); tw(16'h0008, 16'd4);
        tw(16'h000E, 16'd5); tw(16'h0000, 16'd2);
        tr(16'h0000); tr(16'h0000); tr(16'h0000); tr(16'h0000);
        check_log(base, "timeout");
        chk("timeout_done_pulses", 32'(done_cnt - d0), 32'h1);
        repeat (5) @(posedge Clk);
        #1;
        chk("timeout_err_held", 32'(err_timeout), 32'h1);

        // Reset during the strobe of the third write.
        send(16'd10, 16'd20, 16'd21, 16'd22, 16'd23, 16'd24, 16'd25, 0, 1'b0);
        chk("accept_clears_err", 32'(err_timeout), 32'h0);
        repeat (11) @(posedge Clk);
        #2;
        chk("pre_reset_as", 32'(AS_L), 32'h0);
        chk("pre_reset_addr", 32'(AddressOut), 32'h0006);
        d0 = done_cnt;
        Reset_L = 1'b0;
        #1;
        chk("abort_as", 32'(AS_L), 32'h1);
        chk("abort_uds", 32'(UDS_L), 32'h1);
        chk("abort_cs", 32'(GraphicsCS_L), 32'h1);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_ready", 32'(req_ready), 32'h1);
        @(negedge Clk);
        @(negedge Clk); #2;
        Reset_L = 1'b1;
        repeat (4) @(posedge Clk);
        #1;
        chk("abort_no_done", 32'(done_cnt - d0), 32'h0);
        base = log_q.size();
        send(16'd2, 16'd30, 16'd31, 16'd32, 16'd33, 16'd34, 16'd35, 0, 1'b0);
        wait_idle();
        tw(16'h0002, 16'd30); tw(16'h0004, 16'd31); tw(16'h0006, 16'd32); tw(16'h0008, 16'd33);
        tw(16'h000E, 16'd34); tw(16'h0000, 16'd2); tr(16'h0000);
        check_log(base, "after_reset");

        // Back-to-back with req_valid held high; inputs change mid-operation.
        base = log_q.size();
        send(16'd4, 16'd40, 16'd41, 16'd42, 16'd43, 16'd44, 16'd45, 1, 1'b1);
        send(16'd5, 16'd50, 16'd51, 16'd52, 16'd53, 16'd54, 16'd55, 0, 1'b0);
        wait_idle();
        tw(16'h0002, 16'd40); tw(16'h0004, 16'd41); tw(16'h0006, 16'd42); tw(16'h0008, 16'd43);
        tw(16'h000E, 16'd44); tw(16'h0000, 16'd4); tr(16'h0000); tr(16'h0000);
        tw(16'h0002, 16'd50); tw(16'h0004, 16'd51); tw(16'h0006, 16'd52); tw(16'h0008, 16'd53);
        tw(16'h000E, 16'd54); tw(16'h0010, 16'd55); tw(16'h0000, 16'd5); tr(16'h0000);
        check_log(base, "b2b");

        // Random requests checked by the trace model.
        for (int t = 0; t < 12; t++) begin
            repeat ($urandom_range(0, 3)) @(posedge Clk);
            #1;
            send(cmds[$urandom_range(0, 9)], 16'($urandom), 16'($urandom), 16'($urandom),
                 16'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 5)), 1'b0);
            wait_idle();
        end

        repeat (3) @(posedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
